next_pc_seq: RTL and testbench

//  Parametrised PC sequencer for the fetch stage; owns the PC register (no cur_pc loopback).

---
 rtl/pc_pkg.sv | 14 +
 rtl/next_pc_seq_ras_stack.sv | 59 +++++
 rtl/next_pc_seq.sv | 99 +++++++++
 tb/tb_next_pc_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC sequencer: the control-mode encoding.
package pc_pkg;

  localparam int PC_MODE_W = 3;

  typedef enum logic [PC_MODE_W-1:0] {
    MODE_SEQ     = 3'd0,
    MODE_BR_REL  = 3'd1,
    MODE_JMP_ABS = 3'd2,
    MODE_CALL    = 3'd3,
    MODE_RET     = 3'd4
  } pc_mode_e;

endpackage

// File: rtl/next_pc_seq_ras_stack.sv
// Circular return-address stack: push on a full stack overwrites the oldest entry.
// The caller never issues push and pop in the same cycle.
module ras_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               data_in,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_top_idx;
  logic          w_full;

  // r_ptr is the next write slot, so the newest entry sits just below it.
  // Once full, r_ptr also points at the oldest entry, which a push overwrites.
  assign w_top_idx = r_ptr - PW'(1);
  assign w_full    = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;
  assign overflow  = push && w_full;
  assign underflow = pop && empty;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!w_full) begin
        r_count <= r_count + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/next_pc_seq.sv
// Fetch-stage PC sequencer: owns the PC register and picks the next PC from
// sequential/branch/jump/call/return control, with stall, halt and reload.
module next_pc_seq
  import pc_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int PC_INC    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PC_W-1:0]               start_addr,
  input  logic                          valid,
  input  logic                          stall,
  input  logic                          done,
  input  logic [PC_MODE_W-1:0]          mode,
  input  logic                          taken,
  input  logic [PC_W-1:0]               target,
  output logic [PC_W-1:0]               pc,
  output logic                          halted,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  logic [PC_W-1:0] r_pc;
  logic            r_halted;
  logic            r_ovf;
  logic            r_unf;

  logic            w_run;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_ovf;
  logic            w_ras_unf;

  // Only an unstalled, valid cycle on a live sequencer may touch PC or RAS.
  assign w_run    = !r_halted && !done && !stall && valid;
  assign w_push   = w_run && (mode == MODE_CALL);
  assign w_pop    = w_run && (mode == MODE_RET);
  assign w_seq_pc = r_pc + INC;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .data_in   (w_seq_pc),
    .top       (w_ras_top),
    .count     (ras_count),
    .empty     (w_ras_empty),
    .overflow  (w_ras_ovf),
    .underflow (w_ras_unf)
  );

  always_comb begin
    w_next_pc = r_pc;
    if (w_run) begin
      case (mode)
        MODE_BR_REL:  w_next_pc = taken ? (r_pc + target) : w_seq_pc;
        MODE_JMP_ABS: w_next_pc = target;
        MODE_CALL:    w_next_pc = target;
        MODE_RET:     w_next_pc = w_ras_empty ? w_seq_pc : w_ras_top;
        default:      w_next_pc = w_seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= start_addr;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_pc  <= w_next_pc;
      r_ovf <= w_ras_ovf;
      r_unf <= w_ras_unf;
      if (!r_halted && done) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign pc            = r_pc;
  assign halted        = r_halted;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_next_pc_seq.sv
// Self-checking bench for next_pc_seq: directed scenarios plus random traffic,
// compared against a queue-based reference model of the sequencer.
module tb_next_pc_seq;

  logic       clk;
  logic       rst;
  logic [7:0] start_addr;
  logic       valid;
  logic       stall;
  logic       done;
  logic [2:0] mode;
  logic       taken;
  logic [7:0] target;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] ras_count;
  logic       ras_overflow;
  logic       ras_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_pc     = 8'h00;
  logic       m_halted = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       m_unf    = 1'b0;
  logic [7:0] m_ras[$];

  next_pc_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start_addr    (start_addr),
    .valid         (valid),
    .stall         (stall),
    .done          (done),
    .mode          (mode),
    .taken         (taken),
    .target        (target),
    .pc            (pc),
    .halted        (halted),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      m_pc     = start_addr;
      m_halted = 1'b0;
      m_ras.delete();
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (done) begin
      m_halted = 1'b1;
    end else if (!stall && valid) begin
      case (mode)
        3'd1: m_pc = taken ? 8'(m_pc + target) : 8'(m_pc + 8'd1);
        3'd2: m_pc = target;
        3'd3: begin
          m_ras.push_back(8'(m_pc + 8'd1));
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = target;
        end
        3'd4: begin
          if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
          end else begin
            m_pc  = 8'(m_pc + 8'd1);
            m_unf = 1'b1;
          end
        end
        default: m_pc = 8'(m_pc + 8'd1);
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare all outputs.
  task automatic step(input logic r, input logic d, input logic s, input logic v,
                      input logic [2:0] md, input logic t, input logic [7:0] tg);
    rst = r; done = d; stall = s; valid = v; mode = md; taken = t; target = tg;
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", {24'd0, pc}, {24'd0, m_pc});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("ras_count", {29'd0, ras_count}, 32'(m_ras.size()));
    chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
    chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_unf});
  endtask

  task automatic seq_step(input logic [2:0] md, input logic t, input logic [7:0] tg);
    step(1'b0, 1'b0, 1'b0, 1'b1, md, t, tg);
  endtask

  initial begin
    rst = 1'b0; start_addr = 8'h10; valid = 1'b0; stall = 1'b0; done = 1'b0;
    mode = 3'd0; taken = 1'b0; target = 8'h00;

    // 1: reset and sequential fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    chk("s1_reset_pc", {24'd0, pc}, 32'h10);
    chk("s1_reset_cnt", {29'd0, ras_count}, 32'd0);
    seq_step(3'd0, 1'b0, 8'h00);
    seq_step(3'd0, 1'b0, 8'h00);
    seq_step(3'd0, 1'b0, 8'h00);
    chk("s1_pc13", {24'd0, pc}, 32'h13);
    chk("s1_halted", {31'd0, halted}, 32'd0);

    // bubble holds pc
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h55);
    chk("bubble_pc", {24'd0, pc}, 32'h13);

    // 2: branches and wrap
    seq_step(3'd2, 1'b0, 8'h20);
    seq_step(3'd1, 1'b1, 8'hFC);
    chk("s2_br_taken", {24'd0, pc}, 32'h1C);
    seq_step(3'd2, 1'b0, 8'h20);
    seq_step(3'd1, 1'b0, 8'hFC);
    chk("s2_br_not_taken", {24'd0, pc}, 32'h21);
    seq_step(3'd2, 1'b0, 8'hFF);
    seq_step(3'd0, 1'b0, 8'h00);
    chk("s2_wrap", {24'd0, pc}, 32'h00);
    seq_step(3'd6, 1'b1, 8'h77);
    chk("reserved_as_seq", {24'd0, pc}, 32'h01);

    // 3: call and return
    seq_step(3'd2, 1'b0, 8'h05);
    seq_step(3'd3, 1'b0, 8'h40);
    chk("s3_call_pc", {24'd0, pc}, 32'h40);
    chk("s3_call_cnt", {29'd0, ras_count}, 32'd1);
    seq_step(3'd4, 1'b0, 8'h00);
    chk("s3_ret_pc", {24'd0, pc}, 32'h06);
    chk("s3_ret_cnt", {29'd0, ras_count}, 32'd0);

    // 4: nested calls past depth, then unwind
    for (int i = 0; i < 5; i++) begin
      seq_step(3'd3, 1'b0, 8'(8'h80 + 8'(i * 16)));
      chk("s4_ovf_pulse", {31'd0, ras_overflow}, (i == 4) ? 32'd1 : 32'd0);
    end
    seq_step(3'd4, 1'b0, 8'h00);
    chk("s4_ret1", {24'd0, pc}, 32'hB1);
    seq_step(3'd4, 1'b0, 8'h00);
    seq_step(3'd4, 1'b0, 8'h00);
    seq_step(3'd4, 1'b0, 8'h00);
    chk("s4_ret4", {24'd0, pc}, 32'h81);
    seq_step(3'd4, 1'b0, 8'h00);
    chk("s4_underflow", {31'd0, ras_underflow}, 32'd1);
    chk("s4_underflow_pc", {24'd0, pc}, 32'h82);
    seq_step(3'd0, 1'b0, 8'h00);
    chk("s4_unf_clear", {31'd0, ras_underflow}, 32'd0);

    // 5: stall, then done with stall+valid, then ignored inputs, then reset
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'hAA);
    end
    chk("s5_stall_pc", {24'd0, pc}, 32'h83);
    chk("s5_stall_cnt", {29'd0, ras_count}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 8'hAA);
    chk("s5_halted", {31'd0, halted}, 32'd1);
    chk("s5_halt_pc", {24'd0, pc}, 32'h83);
    seq_step(3'd2, 1'b0, 8'h33);
    seq_step(3'd3, 1'b0, 8'h44);
    chk("s5_frozen_pc", {24'd0, pc}, 32'h83);
    start_addr = 8'h10;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    chk("s5_rst_pc", {24'd0, pc}, 32'h10);
    chk("s5_rst_halted", {31'd0, halted}, 32'd0);

    // 6: reset mid-sequence discards RAS
    seq_step(3'd3, 1'b0, 8'h50);
    seq_step(3'd3, 1'b0, 8'h60);
    seq_step(3'd3, 1'b0, 8'h70);
    chk("s6_cnt3", {29'd0, ras_count}, 32'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00);
    chk("s6_rst_cnt", {29'd0, ras_count}, 32'd0);
    seq_step(3'd4, 1'b0, 8'h00);
    chk("s6_underflow", {31'd0, ras_underflow}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic r, s, v;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      start_addr = 8'($urandom);
      step(r, 1'b0, s, v, 3'($urandom_range(0, 7)), 1'($urandom),
           8'($urandom));
    end

    // Random-phase halt, then recovery
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 3'($urandom_range(0, 7)),
           1'($urandom), 8'($urandom));
    end
    start_addr = 8'hE0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    chk("final_rst_pc", {24'd0, pc}, 32'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
